fetch_stage: RTL

- Instruction fetch stage and IF/ID pipeline register, directly upstream of the main/ALU decoder controller.
- Owns the PC and issues requests to the blocking instruction cache, which is qualified by ihit.
- Handles cache-miss waits, taken-branch/jump redirects, hazard stalls and flushes.
- Presents a registered instruction plus split opcode/funct3/funct7 fields to the decode stage.

---
 rtl/fetch_stage.sv | 130 +++++++++++++
 1 files changed

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch stage with IF/ID register, PC control and icache miss/kill handling
// Optional macro FETCH_PERF_CNT_EN adds fetched-instruction and miss-wait cycle counters.
`timescale 1ns/1ps
module fetch_stage #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_ihit,
   input  logic [31:0] i_icache_rdata,
   output logic        o_icache_req,
   output logic [31:0] o_icache_addr,
   input  logic        i_stallD,
   input  logic        i_flushD,
   input  logic        i_redirect,
   input  logic [31:0] i_redirect_pc,
   output logic [31:0] o_instrD,
   output logic [31:0] o_pcD,
   output logic        o_validD,
   output logic [6:0]  o_opcodeD,
   output logic [2:0]  o_funct3D,
   output logic [6:0]  o_funct7D,
   output logic [31:0] o_perf_fetched,
   output logic [31:0] o_perf_miss_cycles
);

   typedef enum logic [1:0] {
      S_RUN  = 2'd0,
      S_MISS = 2'd1,
      S_KILL = 2'd2
   } state_t;

   state_t      r_state;
   logic [31:0] r_pc;
   logic [31:0] r_instr_d;
   logic [31:0] r_pc_d;
   logic        r_valid_d;

   // A flush releases the PC exactly like an unstalled cycle does.
   logic w_advance;
   assign w_advance = !i_stallD || i_flushD;

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         r_state   <= S_RUN;
         r_pc      <= RESET_PC;
         r_instr_d <= NOP_INSTR;
         r_pc_d    <= 32'd0;
         r_valid_d <= 1'b0;
      end else if (i_redirect) begin
         r_pc      <= i_redirect_pc & 32'hFFFF_FFFC;
         r_instr_d <= NOP_INSTR;
         r_valid_d <= 1'b0;
         if (r_state == S_MISS) begin
            r_state <= S_KILL;
         end
      end else begin
         case (r_state)
            S_RUN, S_MISS: begin
               if (i_ihit) begin
                  r_state <= S_RUN;
                  if (w_advance) begin
                     r_pc <= r_pc + 32'd4;
                  end
                  if (i_flushD) begin
                     r_instr_d <= NOP_INSTR;
                     r_valid_d <= 1'b0;
                  end else if (!i_stallD) begin
                     r_instr_d <= i_icache_rdata;
                     r_pc_d    <= r_pc;
                     r_valid_d <= 1'b1;
                  end
               end else begin
                  r_state <= S_MISS;
                  if (w_advance) begin
                     r_instr_d <= NOP_INSTR;
                     r_valid_d <= 1'b0;
                  end
               end
            end
            // The fill returning here belongs to the abandoned address; IF/ID is already a bubble.
            S_KILL: begin
               if (i_ihit) begin
                  r_state <= S_RUN;
               end
            end
            default: r_state <= S_RUN;
         endcase
      end
   end

   assign o_icache_req  = i_reset;
   assign o_icache_addr = r_pc;
   assign o_instrD      = r_instr_d;
   assign o_pcD         = r_pc_d;
   assign o_validD      = r_valid_d;
   assign o_opcodeD     = r_instr_d[6:0];
   assign o_funct3D     = r_instr_d[14:12];
   assign o_funct7D     = r_instr_d[31:25];

`ifdef FETCH_PERF_CNT_EN
   logic [31:0] r_perf_fetched;
   logic [31:0] r_perf_miss_cycles;
   logic        w_capture;

   assign w_capture = !i_redirect && (r_state != S_KILL) && i_ihit && !i_stallD && !i_flushD;

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         r_perf_fetched     <= 32'd0;
         r_perf_miss_cycles <= 32'd0;
      end else begin
         if (w_capture) begin
            r_perf_fetched <= r_perf_fetched + 32'd1;
         end
         if (r_state != S_RUN) begin
            r_perf_miss_cycles <= r_perf_miss_cycles + 32'd1;
         end
      end
   end

   assign o_perf_fetched     = r_perf_fetched;
   assign o_perf_miss_cycles = r_perf_miss_cycles;
`else
   assign o_perf_fetched     = 32'd0;
   assign o_perf_miss_cycles = 32'd0;
`endif

endmodule
